window_fetch_unit: RTL and testbench
====================================

# window_fetch_unit

- Datapath responder to the Sobel controller FSM.
- Fetches pixels from image memory one at a time and assembles the 3x3 pixel window for the gradient units.
- Answers each controller request with a one-cycle done pulse:
  - load_initial -> load_done
  - start_i_read -> read_data_done
  - start_read -> read_done
  - start_shift -> shift_done
  - start_move -> move_done or all_done
- Sits between the controller and the memory read port.

## Interface
- ADDR_W, 16, memory address width
- PIX_W, 8, pixel width
- DIM_W, 10, width/height field width
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- load_initial, start_i_read, start_read, start_shift, start_move  in  1 each  controller requests (levels, acted on rising edge)
- cfg_base  in  ADDR_W  image base address
- cfg_width, cfg_height  in  DIM_W  image dimensions in pixels
- mem_ren  out  1  one-cycle read strobe
- mem_addr  out  ADDR_W  read address, valid with mem_ren
- mem_rdata  in  PIX_W  read data
- mem_rvalid  in  1  mem_rdata valid
- load_done, read_data_done, read_done, shift_done, move_done, all_done  out  1 each  one-cycle pulses
- win_pixels  out  9*PIX_W  slot k = row*3+col, at bits [k*PIX_W +: PIX_W]

## Operation
- Registered state:
  - base, width, height
  - row_top, col_left (window origin)
  - slot pointer sp
  - mode (INIT or REFILL)
  - hold register and its flag hold_v
  - nine window registers
- FSM states and transitions:
  - IDLE: waits for a request.
  - LOAD: latches cfg_*; sets row_top=0, col_left=0, sp=0, mode=INIT, hold_v=0; pulses load_done -> IDLE.
  - ISSUE: mem_ren=1 with mem_addr = base + (row_top + sp/3)*width + col_left + sp%3 -> WAIT.
  - WAIT: on mem_rvalid, hold<=mem_rdata, hold_v=1 -> DONE_RD.
  - DONE_RD: pulses read_data_done -> IDLE.
  - WRWIN: only when hold_v=1. Writes win[sp]<=hold, clears hold_v, pulses read_done, advances sp -> IDLE.
    - INIT mode: sp runs 0..8; after slot 8, mode=REFILL and sp=2.
    - REFILL mode: sp runs 2->5->8->2.
  - SHIFT: win[r*3+c] <= win[r*3+c+1] for c=0,1; column 2 unchanged; sp=2, mode=REFILL; pulses shift_done -> IDLE.
  - MOVE: evaluates the window position, three cases:
    - col_left+3 < width: col_left++; pulses move_done.
    - col_left+3 == width and row_top+3 < height: row_top++, col_left=0 -> ROWLD.
    - col_left+3 == width and row_top+3 == height: pulses all_done; no memory access.
  - ROWLD: six internal fetches into slots 1,2,4,5,7,8. Address = base + (row_top+r)*width + (c-1) for slot column c. The following shift+refill then yields new columns 0..2. After the sixth write, pulses move_done -> IDLE.
- Rising edge of a request = request high now, low in the previous cycle (registered copy).
- Simultaneous rising edges: priority load_initial > start_move > start_shift > start_i_read > start_read.
- Edges arriving outside IDLE are dropped.
- start_read with hold_v=0: ignored, no read_done.
- Address arithmetic is unsigned, truncated modulo 2^ADDR_W.
- mem_rvalid outside WAIT/ROWLD-wait is ignored.

## Timing
- Reset: all outputs 0, win_pixels 0, FSM IDLE, all internal registers 0.
- Reset mid-operation aborts immediately, with no done pulse; a late mem_rvalid is ignored.
- Request edge sampled in cycle N: FSM leaves IDLE at edge N+1.
- load_done, shift_done, move_done (non-wrap) and all_done pulse in cycle N+1.
- Memory reads:
  - mem_ren pulses in cycle N+1.
  - mem_rvalid may arrive 1..any cycles later; one read outstanding at most.
  - read_data_done pulses the cycle after mem_rvalid is sampled.
- read_done pulses in cycle N+1; win_pixels is updated in that same cycle.
- Row wrap: move_done follows the sixth memory return by 2 cycles.
- Every done pulse is exactly one cycle wide.

## Configuration
- WFU_PARAM_CHECK_EN defined:
  - load_initial with cfg_width<3 or cfg_height<3 latches nothing and pulses all_done instead of load_done.
  - start_i_read before any valid load is ignored.
- Undefined: parameters are accepted unchecked and load_done always pulses.

## Test plan
- Initial window: memory returns addr[7:0]; base=0x100, width=5, height=4; load + 9 read/load pairs -> load_done once, 9 read_data_done/read_done, win = 00,01,02,05,06,07,0A,0B,0C.
- Column move: move, shift, 3 pairs -> move_done, shift_done, mem_addr 0x103,0x108,0x10D; win = 01,02,03,06,07,08,0B,0C,0D.
- Row wrap at col_left=2: move -> six mem_ren at 0x105,0x106,0x10A,0x10B,0x10F,0x110, then move_done; shift + 3 pairs -> win = 05,06,07,0A,0B,0C,0F,10,11.
- Last window (row_top=1, col_left=2): move -> all_done pulse, no move_done, no mem_ren.
- Edge cases: start_read with hold_v=0 -> no read_done. Simultaneous start_move and start_shift edges -> only move_done. mem_rvalid delayed 5 cycles -> read_data_done 1 cycle after it.
- n_rst pulsed while in WAIT, then mem_rvalid -> no read_data_done, outputs 0. width=2 load -> all_done with WFU_PARAM_CHECK_EN, load_done without.

Source files
------------

// File: rtl/window_fetch_unit.sv
// window_fetch_unit: fetches image pixels one at a time and assembles the 3x3 Sobel window.
// Define WFU_PARAM_CHECK_EN to reject images smaller than 3x3 and reads before a valid load.
module window_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load_initial,
  input  logic                 start_i_read,
  input  logic                 start_read,
  input  logic                 start_shift,
  input  logic                 start_move,
  input  logic [ADDR_W-1:0]    cfg_base,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  output logic                 mem_ren,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIX_W-1:0]     mem_rdata,
  input  logic                 mem_rvalid,
  output logic                 load_done,
  output logic                 read_data_done,
  output logic                 read_done,
  output logic                 shift_done,
  output logic                 move_done,
  output logic                 all_done,
  output logic [9*PIX_W-1:0]   win_pixels,
  output logic [3:0]           dbg_state
);

  // Handshake: requests are levels and only a rising edge seen while IDLE starts an
  // operation; every accepted operation answers with exactly one single-cycle done pulse.
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE_RD, S_WRWIN, S_SHIFT, S_MOVE,
    S_ROW_ISSUE, S_ROW_WAIT, S_ROW_NEXT
  } state_t;

  typedef enum logic {M_INIT, M_REFILL} mode_t;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [4:0]          req_q, req_d;
  logic [4:0]          req_now, req_rise;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DIM_W-1:0]    width_q, width_d;
  logic [DIM_W-1:0]    height_q, height_d;
  logic [DIM_W-1:0]    row_top_q, row_top_d;
  logic [DIM_W-1:0]    col_left_q, col_left_d;
  logic [3:0]          sp_q, sp_d;
  logic [2:0]          row_cnt_q, row_cnt_d;
  logic [2:0]          row_next;
  logic [3:0]          row_slot;
  logic [PIX_W-1:0]    hold_q, hold_d;
  logic                hold_v_q, hold_v_d;
  logic [PIX_W-1:0]    win_q [9];
  logic [PIX_W-1:0]    win_d [9];
  logic                mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                load_done_q, load_done_d;
  logic                read_data_done_q, read_data_done_d;
  logic                read_done_q, read_done_d;
  logic                shift_done_q, shift_done_d;
  logic                move_done_q, move_done_d;
  logic                all_done_q, all_done_d;
  logic [DIM_W:0]      col_end, row_end;
  logic                load_ok, rd_allowed;
`ifdef WFU_PARAM_CHECK_EN
  logic                cfg_valid_q, cfg_valid_d;
`endif

  // Pixel address base + row*width + col, wrapped to the address width.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [DIM_W-1:0]  w,
                                                 input logic [31:0]       r,
                                                 input logic [31:0]       c);
    logic [31:0] full;
    full = 32'(b) + r * 32'(w) + c;
    return full[ADDR_W-1:0];
  endfunction

  // Bit order matches the priority chain: load > move > shift > i_read > read.
  assign req_now  = {load_initial, start_move, start_shift, start_i_read, start_read};
  assign req_rise = req_now & ~req_q;
  assign col_end  = {1'b0, col_left_q} + (DIM_W+1)'(3);
  assign row_end  = {1'b0, row_top_q} + (DIM_W+1)'(3);
  assign row_next = row_cnt_q + 3'd1;
  assign row_slot = 4'(row_cnt_q[2:1]) * 4'd3 + 4'd1 + 4'(row_cnt_q[0]);

`ifdef WFU_PARAM_CHECK_EN
  assign load_ok    = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3));
  assign rd_allowed = cfg_valid_q;
`else
  assign load_ok    = 1'b1;
  assign rd_allowed = 1'b1;
`endif

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    req_d            = req_now;
    base_d           = base_q;
    width_d          = width_q;
    height_d         = height_q;
    row_top_d        = row_top_q;
    col_left_d       = col_left_q;
    sp_d             = sp_q;
    row_cnt_d        = row_cnt_q;
    hold_d           = hold_q;
    hold_v_d         = hold_v_q;
    for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
    mem_ren_d        = 1'b0;
    mem_addr_d       = mem_addr_q;
    load_done_d      = 1'b0;
    read_data_done_d = 1'b0;
    read_done_d      = 1'b0;
    shift_done_d     = 1'b0;
    move_done_d      = 1'b0;
    all_done_d       = 1'b0;
`ifdef WFU_PARAM_CHECK_EN
    cfg_valid_d      = cfg_valid_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_rise[4]) begin
          state_d = S_LOAD;
          if (load_ok) begin
            base_d      = cfg_base;
            width_d     = cfg_width;
            height_d    = cfg_height;
            row_top_d   = '0;
            col_left_d  = '0;
            sp_d        = '0;
            mode_d      = M_INIT;
            hold_v_d    = 1'b0;
            load_done_d = 1'b1;
`ifdef WFU_PARAM_CHECK_EN
            cfg_valid_d = 1'b1;
`endif
          end else begin
            all_done_d = 1'b1;
          end
        end else if (req_rise[3]) begin
          if (col_end < {1'b0, width_q}) begin
            col_left_d  = col_left_q + DIM_W'(1);
            move_done_d = 1'b1;
            state_d     = S_MOVE;
          end else if (row_end < {1'b0, height_q}) begin
            // Row wrap: preload columns 0,1 of the next row into slot columns 1,2.
            row_top_d  = row_top_q + DIM_W'(1);
            col_left_d = '0;
            row_cnt_d  = '0;
            mem_ren_d  = 1'b1;
            mem_addr_d = pix_addr(base_q, width_q, 32'(row_top_q) + 32'd1, 32'd0);
            state_d    = S_ROW_ISSUE;
          end else begin
            all_done_d = 1'b1;
            state_d    = S_MOVE;
          end
        end else if (req_rise[2]) begin
          for (int r = 0; r < 3; r++) begin
            win_d[r*3]   = win_q[r*3+1];
            win_d[r*3+1] = win_q[r*3+2];
          end
          sp_d         = 4'd2;
          mode_d       = M_REFILL;
          shift_done_d = 1'b1;
          state_d      = S_SHIFT;
        end else if (req_rise[1] && rd_allowed) begin
          mem_ren_d  = 1'b1;
          mem_addr_d = pix_addr(base_q, width_q,
                                32'(row_top_q) + 32'(sp_q / 4'd3),
                                32'(col_left_q) + 32'(sp_q % 4'd3));
          state_d    = S_ISSUE;
        end else if (req_rise[0] && hold_v_q) begin
          win_d[sp_q] = hold_q;
          hold_v_d    = 1'b0;
          read_done_d = 1'b1;
          state_d     = S_WRWIN;
          if (mode_q == M_INIT) begin
            if (sp_q == 4'd8) begin
              mode_d = M_REFILL;
              sp_d   = 4'd2;
            end else begin
              sp_d = sp_q + 4'd1;
            end
          end else begin
            sp_d = (sp_q >= 4'd8) ? 4'd2 : sp_q + 4'd3;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          hold_d           = mem_rdata;
          hold_v_d         = 1'b1;
          read_data_done_d = 1'b1;
          state_d          = S_DONE_RD;
        end
      end
      S_ROW_ISSUE: state_d = S_ROW_WAIT;
      S_ROW_WAIT: begin
        if (mem_rvalid) begin
          win_d[row_slot] = mem_rdata;
          state_d         = S_ROW_NEXT;
        end
      end
      S_ROW_NEXT: begin
        if (row_cnt_q == 3'd5) begin
          move_done_d = 1'b1;
          state_d     = S_MOVE;
        end else begin
          row_cnt_d  = row_next;
          mem_ren_d  = 1'b1;
          mem_addr_d = pix_addr(base_q, width_q,
                                32'(row_top_q) + 32'(row_next[2:1]),
                                32'(col_left_q) + 32'(row_next[0]));
          state_d    = S_ROW_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= S_IDLE;
      mode_q           <= M_INIT;
      req_q            <= '0;
      base_q           <= '0;
      width_q          <= '0;
      height_q         <= '0;
      row_top_q        <= '0;
      col_left_q       <= '0;
      sp_q             <= '0;
      row_cnt_q        <= '0;
      hold_q           <= '0;
      hold_v_q         <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
      mem_ren_q        <= 1'b0;
      mem_addr_q       <= '0;
      load_done_q      <= 1'b0;
      read_data_done_q <= 1'b0;
      read_done_q      <= 1'b0;
      shift_done_q     <= 1'b0;
      move_done_q      <= 1'b0;
      all_done_q       <= 1'b0;
`ifdef WFU_PARAM_CHECK_EN
      cfg_valid_q      <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      req_q            <= req_d;
      base_q           <= base_d;
      width_q          <= width_d;
      height_q         <= height_d;
      row_top_q        <= row_top_d;
      col_left_q       <= col_left_d;
      sp_q             <= sp_d;
      row_cnt_q        <= row_cnt_d;
      hold_q           <= hold_d;
      hold_v_q         <= hold_v_d;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
      mem_ren_q        <= mem_ren_d;
      mem_addr_q       <= mem_addr_d;
      load_done_q      <= load_done_d;
      read_data_done_q <= read_data_done_d;
      read_done_q      <= read_done_d;
      shift_done_q     <= shift_done_d;
      move_done_q      <= move_done_d;
      all_done_q       <= all_done_d;
`ifdef WFU_PARAM_CHECK_EN
      cfg_valid_q      <= cfg_valid_d;
`endif
    end
  end

  always_comb begin
    win_pixels = '0;
    for (int k = 0; k < 9; k++) win_pixels[k*PIX_W +: PIX_W] = win_q[k];
  end

  assign mem_ren        = mem_ren_q;
  assign mem_addr       = mem_addr_q;
  assign load_done      = load_done_q;
  assign read_data_done = read_data_done_q;
  assign read_done      = read_done_q;
  assign shift_done     = shift_done_q;
  assign move_done      = move_done_q;
  assign all_done       = all_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_window_fetch_unit.sv
// Bench for window_fetch_unit: directed image walk plus random images against a
// pixel-grid reference model and a memory responder with variable latency.
module tb_window_fetch_unit;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;
  localparam int DIM_W  = 10;
  localparam logic [4:0] R_LOAD  = 5'b10000;
  localparam logic [4:0] R_MOVE  = 5'b01000;
  localparam logic [4:0] R_SHIFT = 5'b00100;
  localparam logic [4:0] R_IREAD = 5'b00010;
  localparam logic [4:0] R_READ  = 5'b00001;

  logic clk, n_rst;
  logic load_initial, start_i_read, start_read, start_shift, start_move;
  logic [ADDR_W-1:0] cfg_base;
  logic [DIM_W-1:0] cfg_width, cfg_height;
  logic mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0] mem_rdata;
  logic mem_rvalid;
  logic load_done, read_data_done, read_done, shift_done, move_done, all_done;
  logic [9*PIX_W-1:0] win_pixels;
  logic [3:0] dbg_state;

  int n_checks, n_errors;
  int cyc, rv_cyc, lat_cfg;
  int c_load, c_rdd, c_rd, c_shift, c_move, c_all;
  logic [ADDR_W-1:0] exp_q[$];
  int m_base, m_w, m_h, m_row, m_col;

  window_fetch_unit dut (
    .clk(clk), .n_rst(n_rst),
    .load_initial(load_initial), .start_i_read(start_i_read), .start_read(start_read),
    .start_shift(start_shift), .start_move(start_move),
    .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .load_done(load_done), .read_data_done(read_data_done), .read_done(read_done),
    .shift_done(shift_done), .move_done(move_done), .all_done(all_done),
    .win_pixels(win_pixels), .dbg_state(dbg_state)
  );

  // Clock and cycle counter; all driving and sampling happens on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_done)      c_load  <= c_load + 1;
    if (read_data_done) c_rdd   <= c_rdd + 1;
    if (read_done)      c_rd    <= c_rd + 1;
    if (shift_done)     c_shift <= c_shift + 1;
    if (move_done)      c_move  <= c_move + 1;
    if (all_done)       c_all   <= c_all + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference image: pixel (r,c) holds the low byte of its own address.
  function automatic logic [15:0] paddr(input int r, input int c);
    return 16'(m_base + r * m_w + c);
  endfunction

  function automatic logic [7:0] pix(input int r, input int c);
    logic [15:0] a;
    a = paddr(r, c);
    return a[7:0];
  endfunction

  function automatic logic [71:0] exp_win();
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = pix(m_row + k / 3, m_col + k % 3);
    return w;
  endfunction

  // Memory responder: checks each strobe against the expected-address queue.
  initial begin
    logic [15:0] a;
    logic [15:0] e;
    int lat;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (n_rst && mem_ren) begin
        a = mem_addr;
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_ren", a, 72'h0);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", a, e);
        end
        lat = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
        repeat (lat) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = a[7:0];
        rv_cyc     = cyc;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic req_pulse(input logic [4:0] m);
    @(negedge clk);
    {load_initial, start_move, start_shift, start_i_read, start_read} = m;
    @(negedge clk);
    {load_initial, start_move, start_shift, start_i_read, start_read} = 5'b0;
  endtask

  task automatic t_load(input int b, input int w, input int h);
    int l0, a0;
    logic exp_ld;
    cfg_base   = 16'(b);
    cfg_width  = 10'(w);
    cfg_height = 10'(h);
`ifdef WFU_PARAM_CHECK_EN
    exp_ld = (w >= 3 && h >= 3);
`else
    exp_ld = 1'b1;
`endif
    l0 = c_load;
    a0 = c_all;
    req_pulse(R_LOAD);
    chk("load_done", load_done, exp_ld);
    chk("load_all_done", all_done, !exp_ld);
    repeat (2) @(negedge clk);
    chk("load_done_cnt", c_load - l0, exp_ld);
    chk("load_all_cnt", c_all - a0, !exp_ld);
    if (exp_ld) begin
      m_base = b; m_w = w; m_h = h; m_row = 0; m_col = 0;
    end
  endtask

  task automatic do_pair(input int r, input int c, input int slot);
    logic [15:0] a;
    int d0, r0;
    bit seen;
    a = paddr(r, c);
    exp_q.push_back(a);
    d0 = c_rdd;
    r0 = c_rd;
    req_pulse(R_IREAD);
    chk("iread_ren", mem_ren, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (read_data_done) seen = 1'b1;
    end
    chk("rdd_seen", seen, 1'b1);
    if (seen) chk("rdd_latency", cyc, rv_cyc + 1);
    req_pulse(R_READ);
    chk("read_done", read_done, 1'b1);
    chk("win_slot", win_pixels[slot*8 +: 8], a[7:0]);
    @(negedge clk);
    chk("read_done_width", read_done, 1'b0);
    chk("rdd_cnt", c_rdd - d0, 1);
    chk("rd_cnt", c_rd - r0, 1);
  endtask

  task automatic t_stray_read();
    int r0;
    r0 = c_rd;
    req_pulse(R_READ);
    chk("stray_read_done", read_done, 1'b0);
    repeat (2) @(negedge clk);
    chk("stray_rd_cnt", c_rd - r0, 0);
  endtask

  task automatic do_init_window();
    for (int k = 0; k < 9; k++) do_pair(m_row + k / 3, m_col + k % 3, k);
    chk("init_window", win_pixels, exp_win());
  endtask

  task automatic do_shift();
    int s0;
    s0 = c_shift;
    req_pulse(R_SHIFT);
    chk("shift_done", shift_done, 1'b1);
    @(negedge clk);
    chk("shift_done_width", shift_done, 1'b0);
    chk("shift_cnt", c_shift - s0, 1);
  endtask

  task automatic do_refill();
    for (int r = 0; r < 3; r++) do_pair(m_row + r, m_col + 2, 3 * r + 2);
    chk("refill_window", win_pixels, exp_win());
  endtask

  // kind: 0 = step right, 1 = wrap to next row, 2 = last window reached.
  task automatic do_move(input logic [4:0] m, output int kind);
    int mv0, al0, sh0;
    bit seen;
    if (m_col + 3 < m_w) kind = 0;
    else if (m_row + 3 < m_h) kind = 1;
    else kind = 2;
    if (kind == 1)
      for (int n = 0; n < 6; n++) exp_q.push_back(paddr(m_row + 1 + n / 2, n % 2));
    mv0 = c_move; al0 = c_all; sh0 = c_shift;
    req_pulse(m);
    if (kind == 1) begin
      chk("rowld_first_ren", mem_ren, 1'b1);
      chk("rowld_early_move_done", move_done, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        if (move_done) seen = 1'b1;
      end
      chk("rowld_move_done_seen", seen, 1'b1);
      if (seen) chk("rowld_move_latency", cyc, rv_cyc + 2);
    end else begin
      chk("move_done", move_done, kind == 0);
      chk("move_all_done", all_done, kind == 2);
      chk("move_mem_ren", mem_ren, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("move_cnt", c_move - mv0, kind != 2);
    chk("all_cnt", c_all - al0, kind == 2);
    chk("move_shift_cnt", c_shift - sh0, 0);
    if (kind == 0) m_col++;
    if (kind == 1) begin
      m_row++;
      m_col = 0;
      for (int n = 0; n < 6; n++)
        chk("rowld_slot", win_pixels[(3 * (n / 2) + 1 + n % 2)*8 +: 8], pix(m_row + n / 2, n % 2));
    end
  endtask

  initial begin
    int kind;
    int d0;
    n_rst = 1'b0;
    {load_initial, start_move, start_shift, start_i_read, start_read} = 5'b0;
    cfg_base = '0; cfg_width = '0; cfg_height = '0;
    lat_cfg = 0;
    repeat (3) @(negedge clk);
    chk("rst_dones", {load_done, read_data_done, read_done, shift_done, move_done, all_done}, 6'b0);
    chk("rst_mem_ren", mem_ren, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_win", win_pixels, 72'h0);
    chk("rst_state", dbg_state, 4'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed walk over a 5x4 image at 0x100.
    t_load(16'h100, 5, 4);
    do_init_window();
    chk("tp_initial_window", win_pixels, 72'h0C0B0A070605020100);
    t_stray_read();
    do_move(R_MOVE, kind);
    do_shift();
    do_refill();
    chk("tp_column_window", win_pixels, 72'h0D0C0B080706030201);
    do_move(R_MOVE | R_SHIFT, kind);
    do_shift();
    do_refill();
    do_move(R_MOVE, kind);
    do_shift();
    do_refill();
    chk("tp_wrap_window", win_pixels, 72'h11100F0C0B0A070605);
    for (int s = 0; s < 2; s++) begin
      do_move(R_MOVE, kind);
      do_shift();
      do_refill();
    end
    do_move(R_MOVE, kind);
    chk("tp_last_window", win_pixels, exp_win());

    // Slow memory, then reset while a read is outstanding.
    t_load(16'h230, 5, 4);
    lat_cfg = 5;
    do_pair(0, 0, 0);
    lat_cfg = 8;
    exp_q.push_back(paddr(0, 1));
    req_pulse(R_IREAD);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midrst_dones", {load_done, read_data_done, read_done, shift_done, move_done, all_done}, 6'b0);
    chk("midrst_mem_ren", mem_ren, 1'b0);
    chk("midrst_win", win_pixels, 72'h0);
    @(negedge clk);
    n_rst = 1'b1;
    d0 = c_rdd;
    repeat (12) @(negedge clk);
    chk("midrst_late_rvalid", c_rdd - d0, 0);
    chk("midrst_state", dbg_state, 4'd0);
    chk("midrst_win_after", win_pixels, 72'h0);
    lat_cfg = 0;
    t_stray_read();

    t_load(16'h100, 2, 4);

    // Random images traversed end to end.
    for (int img = 0; img < 3; img++) begin
      t_load(int'($urandom_range(0, 65535)), int'($urandom_range(3, 7)), int'($urandom_range(3, 5)));
      do_init_window();
      for (int s = 0; s < 80; s++) begin
        if ($urandom_range(0, 3) == 0) t_stray_read();
        do_move(($urandom_range(0, 1) == 1) ? (R_MOVE | R_SHIFT) : R_MOVE, kind);
        if (kind == 2) break;
        do_shift();
        do_refill();
      end
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
